// File: rtl/minesweeper_pkg.sv
// minesweeper_pkg: shared arbiter state encoding, default fairness limit and saturating counter helper.
package minesweeper_pkg;
  typedef enum logic [1:0] {ARB, LOCKED, FORCE_D} arb_state_e;
  localparam int MAX_WAIT_DEF = 4;
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction
endpackage

// File: rtl/board_mem_arbiter_if.sv
// board_mem_arbiter_if: game port, display port and board RAM port of the board memory arbiter.
interface board_mem_arbiter_if #(parameter int ADDR_W = 8, parameter int DATA_W = 8);
  logic              g_req;
  logic              g_we;
  logic              g_lock;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              g_gnt;
  logic              g_rvalid;
  logic [DATA_W-1:0] g_rdata;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  modport slave (
    input  g_req, g_we, g_lock, g_addr, g_wdata, d_req, d_addr, ram_rdata,
    output g_gnt, g_rvalid, g_rdata, d_gnt, d_rvalid, d_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata
  );
  modport master (
    output g_req, g_we, g_lock, g_addr, g_wdata, d_req, d_addr, ram_rdata,
    input  g_gnt, g_rvalid, g_rdata, d_gnt, d_rvalid, d_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/board_mem_arbiter.sv
// board_mem_arbiter: shares one synchronous-read board RAM between the game controller and display scanner,
// game-priority with lock support and a starvation limit that forces a display grant.
module board_mem_arbiter
  import minesweeper_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  board_mem_arbiter_if.slave bus
);
  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);
  arb_state_e        state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              g_rvalid_q, d_rvalid_q;
  logic              g_gnt, d_gnt;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  always_comb begin
    g_gnt = 1'b0;
    d_gnt = 1'b0;
    case (state_q)
      LOCKED:  g_gnt = bus.g_req;
      FORCE_D: begin
        d_gnt = bus.d_req;
        g_gnt = bus.g_req & ~bus.d_req;
      end
      default: begin
        g_gnt = bus.g_req;
        d_gnt = bus.d_req & ~bus.g_req;
      end
    endcase
    if (reset) begin
      g_gnt = 1'b0;
      d_gnt = 1'b0;
    end
    // the updated count decides the transition, so the forced grant lands one cycle after the limit is hit
    wait_cnt_d = (bus.d_req && !d_gnt) ? sat_inc4(wait_cnt_q) : 4'd0;
    case (state_q)
      LOCKED:  state_d = bus.g_lock ? LOCKED : (wait_cnt_d >= MAX_W ? FORCE_D : ARB);
      FORCE_D: state_d = ARB;
      default: state_d = (g_gnt && bus.g_lock) ? LOCKED : (wait_cnt_d >= MAX_W ? FORCE_D : ARB);
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB;
      wait_cnt_q <= 4'd0;
      g_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      g_rvalid_q <= g_gnt & ~bus.g_we;
      d_rvalid_q <= d_gnt;
    end
  end
  assign ram_addr      = g_gnt ? bus.g_addr : bus.d_addr;
  assign ram_wdata     = g_gnt ? bus.g_wdata : '0;
  assign bus.ram_en    = g_gnt | d_gnt;
  assign bus.ram_we    = g_gnt & bus.g_we;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_wdata = ram_wdata;
  assign bus.g_gnt     = g_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.g_rvalid  = g_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.g_rdata   = bus.ram_rdata;
  assign bus.d_rdata   = bus.ram_rdata;
endmodule

// File: tb/tb_board_mem_arbiter.sv
// tb_board_mem_arbiter: directed stimulus with queued expectations checked by a negedge monitor.
module tb_board_mem_arbiter;
  import minesweeper_pkg::*;
  typedef struct packed {
    logic [1:0] gnt;
    logic       we;
    logic [7:0] addr;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t       exp_q[$];
  logic [7:0] gq[$];
  logic [7:0] dq[$];
  logic [7:0] mem[256];
  bit         mem_init = 1'b0;
  board_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();
  board_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_WAIT(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
      mem_init <= 1'b1;
    end else if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else bus.ram_rdata <= mem[bus.ram_addr];
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  always @(negedge clk) begin
    exp_t e;
    chk("one_grant", 32'(bus.g_gnt & bus.d_gnt), 0);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("grants", {30'd0, bus.g_gnt, bus.d_gnt}, 32'(e.gnt));
      chk("ram_en", 32'(bus.ram_en), 32'(e.gnt != 2'b00));
      if (e.gnt != 2'b00) begin
        chk("ram_we", 32'(bus.ram_we), 32'(e.we));
        chk("ram_addr", 32'(bus.ram_addr), 32'(e.addr));
      end
    end
    if (bus.g_rvalid) begin
      if (gq.size() == 0) chk("g_rvalid_unexpected", 1, 0);
      else chk("g_rdata", 32'(bus.g_rdata), 32'(gq.pop_front()));
    end
    if (bus.d_rvalid) begin
      if (dq.size() == 0) chk("d_rvalid_unexpected", 1, 0);
      else chk("d_rdata", 32'(bus.d_rdata), 32'(dq.pop_front()));
    end
  end
  task automatic cycle(input logic gr, input logic gw, input logic gl, input logic [7:0] ga,
                       input logic [7:0] gd, input logic dr, input logic [7:0] da,
                       input logic [1:0] eg, input logic [7:0] edata);
    bus.g_req = gr; bus.g_we = gw; bus.g_lock = gl; bus.g_addr = ga; bus.g_wdata = gd;
    bus.d_req = dr; bus.d_addr = da;
    exp_q.push_back('{gnt: eg, we: eg[1] & gw, addr: eg[1] ? ga : da});
    if (eg[1] && !gw) gq.push_back(edata);
    if (eg[0]) dq.push_back(edata);
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    cycle(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 2'b00, 8'h00);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] ga, da;
    logic [1:0] eg;
    reset = 1'b1;
    bus.g_req = 0; bus.g_we = 0; bus.g_lock = 0; bus.g_addr = 0; bus.g_wdata = 0;
    bus.d_req = 0; bus.d_addr = 0;
    @(posedge clk);
    #1;
    cycle(1, 0, 0, 8'h12, 8'h00, 1, 8'h34, 2'b00, 8'h00);
    cycle(1, 0, 1, 8'h12, 8'h00, 1, 8'h34, 2'b00, 8'h00);
    chk("rst_state", 32'(dut.state_q), 32'(ARB));
    chk("rst_wait_cnt", 32'(dut.wait_cnt_q), 0);
    chk("rst_g_rvalid", 32'(bus.g_rvalid), 0);
    chk("rst_d_rvalid", 32'(bus.d_rvalid), 0);
    reset = 1'b0;
    idle();
    cycle(1, 0, 0, 8'h12, 8'h00, 0, 8'h00, 2'b10, 8'hB7);
    idle();
    cycle(1, 1, 0, 8'h30, 8'h5A, 0, 8'h00, 2'b10, 8'h00);
    cycle(0, 0, 0, 8'h00, 8'h00, 1, 8'h30, 2'b01, 8'h5A);
    idle();
    cycle(1, 1, 0, 8'h31, 8'h77, 0, 8'h00, 2'b10, 8'h00);
    cycle(1, 0, 0, 8'h31, 8'h00, 0, 8'h00, 2'b10, 8'h77);
    idle();
    for (int i = 0; i < 15; i++) begin
      ga = 8'(i);
      da = 8'h80 + 8'(i);
      eg = (i % 5 == 4) ? 2'b01 : 2'b10;
      cycle(1, 0, 0, ga, 8'h00, 1, da, eg, eg[0] ? (da ^ 8'hA5) : (ga ^ 8'hA5));
    end
    idle();
    for (int i = 0; i < 10; i++) begin
      ga = 8'h40 + 8'(i);
      cycle(1, 0, 1, ga, 8'h00, 1, 8'h90, 2'b10, ga ^ 8'hA5);
    end
    cycle(0, 0, 0, 8'h00, 8'h00, 1, 8'h90, 2'b00, 8'h00);
    cycle(0, 0, 0, 8'h00, 8'h00, 1, 8'h90, 2'b01, 8'h35);
    idle();
    cycle(1, 0, 1, 8'h22, 8'h00, 1, 8'h91, 2'b10, 8'h87);
    bus.g_addr = 8'h23;
    exp_q.push_back('{gnt: 2'b10, we: 1'b0, addr: 8'h23});
    @(negedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_lock_g_rvalid", 32'(bus.g_rvalid), 0);
    chk("mid_lock_state", 32'(dut.state_q), 32'(ARB));
    chk("mid_lock_wait_cnt", 32'(dut.wait_cnt_q), 0);
    cycle(1, 0, 1, 8'h23, 8'h00, 1, 8'h91, 2'b00, 8'h00);
    reset = 1'b0;
    cycle(1, 0, 0, 8'h05, 8'h00, 1, 8'h07, 2'b10, 8'hA0);
    cycle(0, 0, 0, 8'h00, 8'h00, 1, 8'h07, 2'b01, 8'hA2);
    idle();
    idle();
    idle();
    chk("exp_q_drained", 32'(exp_q.size()), 0);
    chk("gq_drained", 32'(gq.size()), 0);
    chk("dq_drained", 32'(dq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/board_mem_arbiter.md
BOARD_MEM_ARBITER -- requirements
Module: board_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, board RAM address width (one tile per address).
REQ-002 Parameter DATA_W, default 8, tile word width.
REQ-003 Parameter MAX_WAIT, default 4, consecutive display denials that force a display grant; legal range 1..15.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high; the ports are named clk and reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 g_req  in  1  game controller access request.
REQ-008 g_we  in  1  game write (1) / read (0), qualified by g_req.
REQ-009 g_lock  in  1  game holds ownership after its grant (read-modify-write).
REQ-010 g_addr  in  ADDR_W  game address; g_wdata  in  DATA_W  game write data.
REQ-011 g_gnt  out  1  game request accepted this cycle.
REQ-012 g_rvalid  out  1  g_rdata valid; g_rdata  out  DATA_W.
REQ-013 d_req  in  1  display scanner read request; d_addr  in  ADDR_W.
REQ-014 d_gnt  out  1  display request accepted this cycle.
REQ-015 d_rvalid  out  1  d_rdata valid; d_rdata  out  DATA_W.
REQ-016 ram_en, ram_we  out  1  RAM strobe/write; ram_addr  out  ADDR_W; ram_wdata  out  DATA_W.
REQ-017 ram_rdata  in  DATA_W  synchronous-read RAM data, one cycle after ram_en with ram_we=0.

Function
REQ-018 At most one of g_gnt, d_gnt SHALL be high per cycle; grants are combinational from requests and registered state.
REQ-019 ram_en = g_gnt|d_gnt; ram_addr/ram_we/ram_wdata SHALL mux from the granted side; d side drives ram_we=0, ram_wdata=0.
REQ-020 FSM states: ARB (normal), LOCKED (game owns RAM), FORCE_D (display priority).
REQ-021 ARB: game has priority; g_gnt=g_req; d_gnt=d_req&~g_req.
REQ-022 ARB: g_gnt with g_lock=1 -> LOCKED next cycle.
REQ-023 LOCKED: d_gnt=0; g_gnt=g_req; stay while g_lock=1; g_lock=0 -> FORCE_D if wait_cnt>=MAX_WAIT else ARB.
REQ-024 wait_cnt (4 bits): +1 (saturating at 15) each cycle d_req=1 and d_gnt=0; cleared on any d_gnt or when d_req=0.
REQ-025 ARB with wait_cnt>=MAX_WAIT and g_lock low -> FORCE_D next cycle.
REQ-026 FORCE_D: d_gnt=d_req; g_gnt=g_req&~d_req; -> ARB next cycle regardless of requests.
REQ-027 Read latency one cycle: g_rvalid registered = g_gnt&~g_we; d_rvalid registered = d_gnt.
REQ-028 g_rdata and d_rdata SHALL both equal ram_rdata; only rvalid discriminates owner.
REQ-029 Writes produce no rvalid; a write and a following read to the same address in consecutive cycles return RAM behaviour unmodified (no forwarding).
REQ-030 Simultaneous g_req and d_req with wait_cnt=MAX_WAIT-1 in ARB: game granted, wait_cnt reaches MAX_WAIT, FORCE_D follows.

Reset
REQ-031 On reset: state=ARB, wait_cnt=0, g_rvalid=d_rvalid=0; grants and ram_en low while reset is high.
REQ-032 Reset mid-LOCKED or mid-read SHALL drop ownership and suppress the pending rvalid.

Structure
REQ-033 State encoding (ARB, LOCKED, FORCE_D) and default MAX_WAIT SHALL live in shared package minesweeper_pkg.
REQ-034 No sub-module; single flat block.

Verification
REQ-035 g_req=1,g_we=0,addr=0x12 alone -> g_gnt same cycle, g_rvalid next cycle, g_rdata=RAM[0x12].
REQ-036 g_req and d_req continuously high, MAX_WAIT=4 -> d_gnt every 5th cycle, never two grants in one cycle.
REQ-037 g_lock=1 for 10 cycles with d_req high -> zero d_gnt during lock, d_gnt in first cycle after release.
REQ-038 g write 0x5A to 0x30 then d read 0x30 -> d_rvalid with d_rdata=0x5A, g_rvalid stays 0.
REQ-039 reset asserted in LOCKED with read in flight -> no rvalid, state ARB, wait_cnt=0.
